// File: rtl/boot_ctrl_pkg.sv
// boot_ctrl_pkg: state encoding and default sizes shared by ram_boot_ctrl
package boot_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, RUN} state_t;
  localparam int DEF_PROG_LEN = 16;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
endpackage

// File: rtl/ram_boot_ctrl.sv
// ram_boot_ctrl: streams a program into instruction RAM at boot, then releases the CPU
// Ports: clk, reset (async active-low); start begins a (re)load; ld_valid/ld_ready/ld_data loader
// stream; cpu_addr -> ram_raddr fetch path; ram_we/ram_waddr/ram_wdata RAM write port;
// cpu_hold CPU reset; busy in LOAD/DRAIN; checksum = wrapping sum of the loaded bytes.
module ram_boot_ctrl
  import boot_ctrl_pkg::*;
#(
  parameter int PROG_LEN = DEF_PROG_LEN,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic [3:0]        cpu_addr,
  output logic              cpu_hold,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              busy,
  output logic [DATA_W-1:0] checksum
);
  // count is one bit wider than the address so PROG_LEN=2**ADDR_W never wraps to address 0
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(PROG_LEN - 1);
  state_t state;
  logic [ADDR_W:0] count;
  logic xfer;
  assign xfer = ld_valid && ld_ready;
  // fetch address passes straight through in RUN so CPU fetch latency is unchanged
  always_comb ram_raddr = state == RUN ? ADDR_W'(cpu_addr) : '0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      cpu_hold <= 1'b1;
      ld_ready <= 1'b0;
      busy <= 1'b0;
      ram_we <= 1'b0;
      ram_waddr <= '0;
      ram_wdata <= '0;
      checksum <= '0;
    end else begin
      ram_we <= xfer;
      if (xfer) begin
        ram_waddr <= count[ADDR_W-1:0];
        ram_wdata <= ld_data;
        count <= count + (ADDR_W+1)'(1);
        checksum <= checksum + ld_data;
      end
      case (state)
        IDLE, RUN: if (start) begin
          state <= LOAD;
          count <= '0;
          checksum <= '0;
          ld_ready <= 1'b1;
          busy <= 1'b1;
          cpu_hold <= 1'b1;
        end
        LOAD: if (xfer && count == LAST) begin
          state <= DRAIN;
          ld_ready <= 1'b0;
        end
        DRAIN: begin
          state <= RUN;
          busy <= 1'b0;
          cpu_hold <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ram_boot_ctrl.sv
// tb_ram_boot_ctrl: directed vectors and load sequences for ram_boot_ctrl
module tb_ram_boot_ctrl;
  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;
  logic start = 0, ld_valid = 0, ld_ready, cpu_hold, ram_we, busy;
  logic [7:0] ld_data = 0, ram_raddr, ram_waddr, ram_wdata, checksum;
  logic [3:0] cpu_addr = 0;
  logic b_start = 0, b_valid = 0, b_ready, b_hold, b_we, b_busy;
  logic [7:0] b_data = 8'hFF, b_raddr, b_waddr, b_wdata, b_csum;
  logic [3:0] b_caddr = 0;
  int n_cmp = 0, n_bad = 0;
  logic [15:0] wq[$];
  bit prev_x = 0;
  int b_nw = 0, b_zero = 0;
  logic [7:0] b_last = 0;

  ram_boot_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .cpu_addr(cpu_addr), .cpu_hold(cpu_hold), .ram_raddr(ram_raddr),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .busy(busy),
    .checksum(checksum)
  );
  ram_boot_ctrl #(.PROG_LEN(256)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .ld_valid(b_valid), .ld_data(b_data),
    .ld_ready(b_ready), .cpu_addr(b_caddr), .cpu_hold(b_hold), .ram_raddr(b_raddr),
    .ram_we(b_we), .ram_waddr(b_waddr), .ram_wdata(b_wdata), .busy(b_busy),
    .checksum(b_csum)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // ram_we must be high exactly in the cycle after each accepted byte
  always @(negedge clk) begin
    if (!reset) prev_x = 0;
    else begin
      chk("we_timing", ram_we, prev_x);
      if (ram_we) wq.push_back({ram_waddr, ram_wdata});
      prev_x = ld_valid && ld_ready;
    end
  end

  always @(negedge clk)
    if (reset && b_we) begin
      b_nw++;
      b_last = b_waddr;
      if (b_waddr == 8'h00) b_zero++;
    end

  task automatic pulse_start();
    start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic send(input int n, input bit gap, input logic [7:0] base);
    int i = 0;
    int cyc = 0;
    bit ph = 0;
    while (i < n && cyc < 1000) begin
      ld_valid = gap ? ph : 1'b1;
      ld_data = base + 8'(i);
      ph = !ph;
      @(negedge clk);
      if (ld_valid && ld_ready) i++;
      @(posedge clk); #1;
      cyc++;
    end
    ld_valid = 0;
    chk("load_done", i, n);
  endtask

  task automatic drain_run();
    @(negedge clk);
    chk("drain_hold", cpu_hold, 1);
    chk("drain_busy", busy, 1);
    chk("drain_ready", ld_ready, 0);
    chk("drain_we", ram_we, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("run_hold", cpu_hold, 0);
    chk("run_busy", busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic chk_writes(input int n, input logic [7:0] base);
    chk("n_writes", wq.size(), n);
    for (int i = 0; i < n && i < wq.size(); i++)
      chk($sformatf("write%0d", i), wq[i], {8'(i), base + 8'(i)});
  endtask

  typedef struct {
    logic start, valid;
    logic [7:0] data;
    logic [3:0] caddr;
    logic e_hold, e_ready, e_busy, e_we;
    logic [7:0] e_raddr, e_csum;
  } vec_t;
  vec_t tv[7];

  initial begin
    int cyc;
    tv[0] = '{1'b0, 1'b0, 8'h00, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0A, 8'h78};
    tv[1] = '{1'b0, 1'b0, 8'h00, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h03, 8'h78};
    tv[2] = '{1'b1, 1'b1, 8'h55, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h03, 8'h78};
    tv[3] = '{1'b0, 1'b1, 8'h55, 4'h3, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00};
    tv[4] = '{1'b0, 1'b0, 8'h00, 4'h3, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h55};
    tv[5] = '{1'b1, 1'b1, 8'h01, 4'h3, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h55};
    tv[6] = '{1'b0, 1'b0, 8'h00, 4'h3, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h56};
    #2 reset = 0;
    repeat (3) @(negedge clk);
    chk("rst_hold", cpu_hold, 1);
    chk("rst_ready", ld_ready, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_waddr", ram_waddr, 0);
    chk("rst_wdata", ram_wdata, 0);
    chk("rst_raddr", ram_raddr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_csum", checksum, 0);
    @(posedge clk); #1;
    reset = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_hold", cpu_hold, 1);
      chk("idle_ready", ld_ready, 0);
      chk("idle_we", ram_we, 0);
    end
    @(posedge clk); #1;
    wq.delete();
    pulse_start();
    send(16, 0, 8'h10);
    drain_run();
    chk_writes(16, 8'h10);
    chk("csum_b2b", checksum, 8'h78);
    wq.delete();
    for (int i = 0; i < 7; i++) begin
      start = tv[i].start;
      ld_valid = tv[i].valid;
      ld_data = tv[i].data;
      cpu_addr = tv[i].caddr;
      @(negedge clk);
      chk($sformatf("v%0d_hold", i), cpu_hold, tv[i].e_hold);
      chk($sformatf("v%0d_ready", i), ld_ready, tv[i].e_ready);
      chk($sformatf("v%0d_busy", i), busy, tv[i].e_busy);
      chk($sformatf("v%0d_we", i), ram_we, tv[i].e_we);
      chk($sformatf("v%0d_raddr", i), ram_raddr, tv[i].e_raddr);
      chk($sformatf("v%0d_csum", i), checksum, tv[i].e_csum);
      @(posedge clk); #1;
    end
    start = 0;
    ld_valid = 0;
    chk("tbl_nw", wq.size(), 2);
    chk("tbl_w0", wq[0], 16'h0055);
    chk("tbl_w1", wq[1], 16'h0101);
    send(3, 0, 8'h20);
    @(posedge clk); #1;
    ld_valid = 1;
    ld_data = 8'h99;
    reset = 0;
    #1;
    chk("mid_rst_ready", ld_ready, 0);
    chk("mid_rst_hold", cpu_hold, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_we", ram_we, 0);
    chk("mid_rst_csum", checksum, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_ready", ld_ready, 0);
      chk("post_rst_hold", cpu_hold, 1);
    end
    @(posedge clk); #1;
    ld_valid = 0;
    chk("mid_nw", wq.size(), 5);
    chk("mid_w2", wq[2], 16'h0220);
    chk("mid_w4", wq[4], 16'h0422);
    wq.delete();
    pulse_start();
    send(16, 1, 8'h10);
    drain_run();
    chk_writes(16, 8'h10);
    chk("csum_gap", checksum, 8'h78);
    b_start = 1;
    @(posedge clk); #1;
    b_start = 0;
    b_valid = 1;
    cyc = 0;
    while (b_hold && cyc < 600) begin
      @(posedge clk); #1;
      cyc++;
    end
    b_valid = 0;
    chk("b_run_hold", b_hold, 0);
    chk("b_nw", b_nw, 256);
    chk("b_last", b_last, 8'hFF);
    chk("b_zero_writes", b_zero, 1);
    chk("b_csum", b_csum, 8'h00);
    chk("b_busy", b_busy, 0);
    chk("b_ready", b_ready, 0);
    chk("b_raddr", b_raddr, 8'h00);
    repeat (3) @(posedge clk);
    #1 chk("b_nw_after", b_nw, 256);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ram_boot_ctrl.md
# ram_boot_ctrl

Boot-time controller that owns the shared instruction RAM and sequences the CPU around it. After reset it holds the CPU in reset and accepts a program byte stream over a valid/ready port. It writes the bytes into RAM from address 0 upward, then releases the CPU and hands the RAM read address to the CPU fetch path. It sits between the top-level loader input, the `cpu` instance and the `ram` instance, and drives the RAM write port that is otherwise unused.

## Interface
- `PROG_LEN`, 16: number of bytes loaded per boot (1..256).
- `ADDR_W`, 8: RAM address width.
- `DATA_W`, 8: RAM data width.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low; low forces the reset state immediately.
- `start`  in  1  single-cycle pulse; begins a (re)load.
- `ld_valid`  in  1  loader byte valid.
- `ld_data`  in  DATA_W  loader byte.
- `ld_ready`  out  1  controller accepts a byte this cycle.
- `cpu_addr`  in  4  CPU fetch address.
- `cpu_hold`  out  1  active-high reset to the CPU.
- `ram_raddr`  out  ADDR_W  RAM read address.
- `ram_we`  out  1  RAM write enable.
- `ram_waddr`  out  ADDR_W  RAM write address.
- `ram_wdata`  out  DATA_W  RAM write data.
- `busy`  out  1  high in LOAD and DRAIN.
- `checksum`  out  DATA_W  mod-256 sum of the bytes from the last completed or in-progress load.

## Operation
- States: IDLE, LOAD, DRAIN, RUN.
- IDLE:
  - `cpu_hold`=1, `ld_ready`=0.
  - `start` -> LOAD; clear count and checksum.
- LOAD:
  - `ld_ready`=1.
  - A transfer (`ld_valid`&`ld_ready` at a rising edge) registers `ram_waddr`=count and `ram_wdata`=`ld_data`, with `ram_we`=1 in the following cycle.
  - Each transfer increments count and adds the byte to `checksum` (wraps mod 256).
  - The transfer with count=PROG_LEN-1 -> DRAIN. `ld_ready` is 0 from the next cycle.
  - `start` is ignored while in LOAD.
- DRAIN: one cycle; the final write is on the RAM port this cycle; -> RUN.
- RUN:
  - `cpu_hold`=0.
  - `ram_raddr`={0, `cpu_addr`}.
  - `start` -> LOAD: `cpu_hold`=1 the next cycle; count and checksum cleared.
- Outside RUN: `ram_raddr`=0.
- `ram_we` is 1 only in the cycle after a transfer. Gaps in `ld_valid` produce gaps in `ram_we`.
- count width is ADDR_W+1. When PROG_LEN=256, the last `ram_waddr` is 255 and the count never wraps into address 0.

## Timing
- Reset values: state IDLE, `cpu_hold`=1, `ld_ready`=0, `ram_we`=0, `ram_waddr`=0, `ram_wdata`=0, `ram_raddr`=0, `busy`=0, `checksum`=0.
- All outputs are registered except `ram_raddr` in RUN, which is combinational from `cpu_addr` so fetch latency is unchanged.
- Transfer to RAM write: 1 cycle.
- Final transfer to `cpu_hold` low: 2 cycles (DRAIN, then RUN).
- Reset low mid-load: the load is abandoned, no further writes occur, and the controller returns to IDLE. RAM contents already written are kept.
- `start` and the final transfer in the same cycle: `start` is ignored.
- `start` in RUN together with `ld_valid`: the byte is not accepted until the first LOAD cycle.

## Structure
- Package `boot_ctrl_pkg`: state enum (IDLE, LOAD, DRAIN, RUN) and default width constants.
- No sub-module. Single FSM, one count register, one write register stage, one checksum accumulator.
- `top` instantiates it; the `ram` write port and the CPU reset are driven from it.

## Test plan
- Reset released, no `start` for 20 cycles -> `cpu_hold`=1, `ram_we` never 1, `ld_ready`=0.
- `start`, then 16 back-to-back bytes 0x10..0x1F -> 16 writes to addr 0..15 with matching data, one cycle after each transfer. `checksum`=0x78. `cpu_hold` falls 2 cycles after the last transfer.
- Same stream with `ld_valid` toggling every other cycle -> writes only after accepted bytes, addresses contiguous 0..15, same checksum.
- In RUN, drive `cpu_addr`=0xA -> `ram_raddr`=0x0A in the same cycle. A `start` pulse -> `cpu_hold`=1 next cycle and `checksum`=0.
- Reset low after 5 bytes -> immediate IDLE, no 6th write. After `start` a fresh load begins at address 0.
- `PROG_LEN`=256 with bytes 0xFF each -> last write at address 0xFF, `checksum`=0x00, then RUN.
